blood_fx_ctrl: RTL
==================

Name: blood_fx_ctrl

Overview:
- Schedules and shares the single 64x64 blood-splat sprite ROM (12-bit colour, 6-bit row/col address, one-cycle read latency) between two player hit-effect requesters.
- On a hit pulse it anchors a splat at the given screen position and keeps it visible for a fixed number of frames.
- Per VGA pixel it selects the owning player, drives the ROM row/col address and produces a latency-aligned overlay pixel for the pixel mux.

Parameters:
- HOLD_FRAMES, 30: frames a splat stays visible after activation; legal range 1..255.
- FAIR, 0: 0 = P1 always wins on overlap; 1 = winner alternates every frame_tick, starting with P1 after reset.

Ports:
- clk  in  1  system/pixel clock
- reset  in  1  synchronous, active-high
- video_on  in  1  display-area flag for the current x/y
- x  in  10  current pixel column
- y  in  10  current pixel row
- frame_tick  in  1  one-cycle pulse once per frame, in vblank
- hit_p1  in  1  one-cycle pulse, P1 has been struck
- hit_p2  in  1  one-cycle pulse, P2 has been struck
- p1_x  in  10  splat top-left column for P1, sampled on hit_p1
- p1_y  in  10  splat top-left row for P1, sampled on hit_p1
- p2_x  in  10  splat top-left column for P2, sampled on hit_p2
- p2_y  in  10  splat top-left row for P2, sampled on hit_p2
- rom_row  out  6  sprite ROM row address
- rom_col  out  6  sprite ROM column address
- rom_data  in  12  sprite ROM colour, valid one cycle after the address
- blood_on  out  1  overlay pixel valid (opaque)
- blood_rgb  out  12  overlay colour
- busy_p1  out  1  P1 channel active or pending
- busy_p2  out  1  P2 channel active or pending

Behaviour:
- Reset:
  - Both channels IDLE; pending flags and counters cleared; anchors set to 0; FAIR priority bit selects P1.
  - All outputs are 0 in the cycle after reset is sampled high.
  - Reset mid-frame blanks the overlay immediately.
- Channel states: IDLE and ACTIVE, plus a separate pending bit with a pending anchor.
- hit_pk in any state:
  - Sets pending.
  - Latches p_k_x/p_k_y into the pending anchor.
  - A later hit before the next frame_tick overwrites the pending anchor.
- frame_tick with pending set:
  - Copies the pending anchor to the display anchor.
  - Loads counter = HOLD_FRAMES, clears pending, goes to ACTIVE.
  - Applies from either state, so it is a retrigger when already ACTIVE.
- frame_tick with ACTIVE and no pending:
  - Decrements the counter.
  - If the counter was 1, goes to IDLE.
  - Result: a splat is visible for exactly HOLD_FRAMES full frames.
- Same-cycle events:
  - hit and frame_tick in the same cycle: the hit becomes pending and applies at the following frame_tick.
  - hit_p1 and hit_p2 in the same cycle: handled independently.
- Anchors change only at frame_tick, so splats never tear mid-frame.
- busy_pk = ACTIVE or pending.
- Window test for channel k:
  - ACTIVE and x >= ax and (x - ax) < 64 and y >= ay and (y - ay) < 64.
  - Use 11-bit differences so there is no wrap-around.
  - Splats anchored near the right/bottom edge are clipped naturally.
- Selection (cycle N):
  - Only one channel inside its window: that channel owns the pixel.
  - Both inside: the priority channel owns it (fixed P1 when FAIR=0; toggling bit when FAIR=1).
  - rom_row = (y - ay)[5:0] and rom_col = (x - ax)[5:0] of the owner; both 0 when no owner.
  - Address outputs are combinational from x/y and registered state.
- Alignment (cycle N+1):
  - sel_d register = owner-exists AND video_on.
  - blood_on = sel_d AND (rom_data != 12'h000); colour 000 is transparent.
  - blood_rgb = rom_data when blood_on, else 0.
- Latency: x/y at cycle N produce blood_on/blood_rgb at cycle N+1; this matches the ROM's registered address.
- Counter width: 8 bits.

Decomposition:
- Shared package (blood_fx_pkg):
  - SPRITE_DIM = 64, SPRITE_AW = 6, COLOR_W = 12, TRANSPARENT = 12'h000, PIX_W = 10.
  - Channel state encoding: IDLE = 0, ACTIVE = 1.
- Sub-module blood_fx_channel, instantiated twice:
  - Contents: state, pending, anchors, frame counter, window test.
  - Outputs: in_win, rel_row, rel_col, busy.
- The top level holds the priority bit, the owner mux, the sel_d pipeline register and the transparency gate.

Test Plan:
- HOLD_FRAMES=3, FAIR=0. hit_p1 with p1=(100,200), then 5 frame_ticks, pixel x=110, y=205, ROM word opaque:
  - busy_p1 rises the cycle after the hit.
  - blood_on=1 one cycle after the pixel, in frames 1-3 only.
  - rom_row=5, rom_col=10.
  - busy_p1=0 after the 4th tick.
- Latency/transparency: during ACTIVE, ROM model returns 12'h000 for one address and 12'hE00 for the next:
  - blood_on goes 0 then 1, each one cycle after its address.
  - blood_rgb=12'hE00 on the opaque pixel.
- Overlap: both channels active at (300,100) and (320,100), pixel x=330:
  - FAIR=0: rom_col=30, every frame.
  - FAIR=1: rom_col alternates 30/10 on successive frames.
- Clipping/wrap: p2 anchor (600,450), pixels x=639, y=479 and x=5, y=5:
  - First pixel is inside with rom_col=39, rom_row=29.
  - Second pixel never selects channel 2; no negative wrap.
- Same-cycle and retrigger:
  - hit_p1 coincident with frame_tick: activation occurs only at the next tick.
  - hit_p1 at (50,50) while ACTIVE at (100,100): old splat stays at (100,100) until the next tick, then moves to (50,50) with counter reloaded to HOLD_FRAMES.
- Reset mid-frame while both channels are active and pending:
  - One cycle later blood_on=0, rom_row=0, rom_col=0, busy_p1=0, busy_p2=0.
  - The next frame_tick with no new hit produces no activation.

Source files
------------

// File: rtl/blood_fx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : blood_fx_pkg
// Purpose  : Shared constants and types for the blood-splat overlay
//            controller (sprite geometry, colour width, channel states).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package blood_fx_pkg;

  localparam int SPRITE_DIM = 64;   // splat sprite is SPRITE_DIM x SPRITE_DIM
  localparam int SPRITE_AW  = 6;    // row/col address width into the ROM
  localparam int COLOR_W    = 12;   // 4:4:4 RGB
  localparam int PIX_W      = 10;   // screen coordinate width
  localparam int CNT_W      = 8;    // frame hold counter width

  // Colour value that the ROM uses for "no paint here".
  localparam logic [COLOR_W-1:0] TRANSPARENT = 12'h000;

  typedef enum logic [0:0] {
    CH_IDLE   = 1'b0,
    CH_ACTIVE = 1'b1
  } ch_state_e;

endpackage : blood_fx_pkg
`default_nettype wire

// File: rtl/blood_fx_channel.sv
`default_nettype none
// ============================================================================
// Module   : blood_fx_channel
// Purpose  : One hit-effect channel. Captures a hit as a pending anchor,
//            promotes it to the displayed anchor on frame_tick, holds it for
//            HOLD_FRAMES frames and tests the current pixel against the
//            64x64 splat window.
// Ports    : clk, reset           - clock, synchronous active-high reset
//            frame_tick           - once-per-frame pulse (vblank)
//            hit, hit_x, hit_y    - strike pulse and splat top-left corner
//            x, y                 - current pixel
//            in_win               - pixel lies inside the active splat
//            rel_row, rel_col     - pixel offset inside the splat
//            busy                 - channel active or a hit is pending
// Revision : 1.0 - initial release
// ============================================================================
module blood_fx_channel
  import blood_fx_pkg::*;
#(
  parameter int HOLD_FRAMES = 30
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic                 hit,
  input  logic [PIX_W-1:0]     hit_x,
  input  logic [PIX_W-1:0]     hit_y,
  input  logic [PIX_W-1:0]     x,
  input  logic [PIX_W-1:0]     y,
  output logic                 in_win,
  output logic [SPRITE_AW-1:0] rel_row,
  output logic [SPRITE_AW-1:0] rel_col,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_FRAMES);

  ch_state_e          state, state_nx;
  logic               pend, pend_nx;
  logic [PIX_W-1:0]   pend_x, pend_x_nx, pend_y, pend_y_nx;
  logic [PIX_W-1:0]   anc_x, anc_x_nx, anc_y, anc_y_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= CH_IDLE;
      pend   <= 1'b0;
      pend_x <= '0;
      pend_y <= '0;
      anc_x  <= '0;
      anc_y  <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nx;
      pend   <= pend_nx;
      pend_x <= pend_x_nx;
      pend_y <= pend_y_nx;
      anc_x  <= anc_x_nx;
      anc_y  <= anc_y_nx;
      cnt    <= cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    pend_nx   = pend;
    pend_x_nx = pend_x;
    pend_y_nx = pend_y;
    anc_x_nx  = anc_x;
    anc_y_nx  = anc_y;
    cnt_nx    = cnt;

    // The displayed anchor only moves at frame_tick so a splat never tears.
    if (frame_tick) begin
      if (pend) begin
        anc_x_nx = pend_x;
        anc_y_nx = pend_y;
        cnt_nx   = HOLD_LD;
        pend_nx  = 1'b0;
        state_nx = CH_ACTIVE;
      end else if (state == CH_ACTIVE) begin
        cnt_nx = cnt - 8'd1;
        if (cnt == 8'd1) begin
          state_nx = CH_IDLE;
        end
      end
    end

    // Evaluated after the tick so a coincident hit stays pending for the
    // following frame instead of being consumed now.
    if (hit) begin
      pend_nx   = 1'b1;
      pend_x_nx = hit_x;
      pend_y_nx = hit_y;
    end
  end

  // 11-bit differences: a pixel left of / above the anchor borrows into the
  // top bit and therefore fails the "< 64" test, so there is no wrap-around.
  logic [PIX_W:0] dx, dy;
  assign dx = {1'b0, x} - {1'b0, anc_x};
  assign dy = {1'b0, y} - {1'b0, anc_y};

  assign in_win  = (state == CH_ACTIVE) &&
                   (dx < (PIX_W+1)'(SPRITE_DIM)) &&
                   (dy < (PIX_W+1)'(SPRITE_DIM));
  assign rel_col = dx[SPRITE_AW-1:0];
  assign rel_row = dy[SPRITE_AW-1:0];
  assign busy    = (state == CH_ACTIVE) || pend;

endmodule : blood_fx_channel
`default_nettype wire

// File: rtl/blood_fx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : blood_fx_ctrl
// Purpose  : Shares one 64x64 blood-splat sprite ROM between two player
//            hit-effect channels and produces a ROM-latency-aligned overlay.
// Ports    : clk, reset                 - clock, synchronous active-high reset
//            video_on, x, y             - current pixel and display flag
//            frame_tick                 - once-per-frame pulse
//            hit_p1/p2, p1_x/y, p2_x/y  - strike pulses and splat anchors
//            rom_row, rom_col           - sprite ROM address (combinational)
//            rom_data                   - ROM colour, one cycle after address
//            blood_on, blood_rgb        - overlay pixel for the pixel mux
//            busy_p1, busy_p2           - channel active or pending
// Revision : 1.0 - initial release
// ============================================================================
module blood_fx_ctrl
  import blood_fx_pkg::*;
#(
  parameter int HOLD_FRAMES = 30,
  parameter int FAIR        = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 video_on,
  input  logic [PIX_W-1:0]     x,
  input  logic [PIX_W-1:0]     y,
  input  logic                 frame_tick,
  input  logic                 hit_p1,
  input  logic                 hit_p2,
  input  logic [PIX_W-1:0]     p1_x,
  input  logic [PIX_W-1:0]     p1_y,
  input  logic [PIX_W-1:0]     p2_x,
  input  logic [PIX_W-1:0]     p2_y,
  output logic [SPRITE_AW-1:0] rom_row,
  output logic [SPRITE_AW-1:0] rom_col,
  input  logic [COLOR_W-1:0]   rom_data,
  output logic                 blood_on,
  output logic [COLOR_W-1:0]   blood_rgb,
  output logic                 busy_p1,
  output logic                 busy_p2
);

  logic                 win1, win2;
  logic [SPRITE_AW-1:0] row1, col1, row2, col2;
  logic                 prio_p2;   // 0: P1 wins on overlap, 1: P2 wins
  logic                 own1, own2;
  logic                 sel_d;

  blood_fx_channel #(.HOLD_FRAMES(HOLD_FRAMES)) u_ch_p1 (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .hit        (hit_p1),
    .hit_x      (p1_x),
    .hit_y      (p1_y),
    .x          (x),
    .y          (y),
    .in_win     (win1),
    .rel_row    (row1),
    .rel_col    (col1),
    .busy       (busy_p1)
  );

  blood_fx_channel #(.HOLD_FRAMES(HOLD_FRAMES)) u_ch_p2 (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .hit        (hit_p2),
    .hit_x      (p2_x),
    .hit_y      (p2_y),
    .x          (x),
    .y          (y),
    .in_win     (win2),
    .rel_row    (row2),
    .rel_col    (col2),
    .busy       (busy_p2)
  );

  // With FAIR set the overlap winner swaps each frame; otherwise P1 keeps it.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_p2 <= 1'b0;
    end else if ((FAIR != 0) && frame_tick) begin
      prio_p2 <= ~prio_p2;
    end
  end

  assign own1 = win1 && (!win2 || !prio_p2);
  assign own2 = win2 && !own1;

  always_comb begin
    rom_row = '0;
    rom_col = '0;
    if (own1) begin
      rom_row = row1;
      rom_col = col1;
    end else if (own2) begin
      rom_row = row2;
      rom_col = col2;
    end
  end

  // Delays the "pixel selected" decision by the ROM's one-cycle read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_d <= 1'b0;
    end else begin
      sel_d <= (win1 || win2) && video_on;
    end
  end

  assign blood_on  = sel_d && (rom_data != TRANSPARENT);
  assign blood_rgb = blood_on ? rom_data : '0;

endmodule : blood_fx_ctrl
`default_nettype wire
